// File: rtl/dvp_rgb565_capture_pkg.sv
// dvp_rgb565_capture_pkg: shared state enum, pixel type and counter widths for the DVP capture block
package dvp_rgb565_capture_pkg;
   localparam int HCNT_W = 12;
   localparam int VCNT_W = 11;
   localparam int SKIP_W = 8;
   typedef enum logic [1:0] {WAIT_VS, SKIP, ARM, ACTIVE} cap_state_t;
   typedef logic [15:0] rgb565_t;
endpackage

// File: rtl/dvp_sync_edge.sv
// dvp_sync_edge: registers the DVP pins once and flags vsync/href edges against a second stage
//   clk, reset                                  capture clock, synchronous active-high reset
//   vsync_in, href_in, data_in                  raw DVP pins
//   r_vsync, r_href, r_data                     first-stage registered pins
//   vsync_rise, vsync_fall, href_rise, href_fall single-cycle edge flags aligned with r_*
module dvp_sync_edge (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync_in,
   input  logic       href_in,
   input  logic [7:0] data_in,
   output logic       r_vsync,
   output logic       r_href,
   output logic [7:0] r_data,
   output logic       vsync_rise,
   output logic       vsync_fall,
   output logic       href_rise,
   output logic       href_fall
);
   logic       vsync_q, href_q, vsync_dly_q, href_dly_q;
   logic [7:0] data_q;
   always_ff @(posedge clk)
      if (reset) begin
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= '0;
         vsync_dly_q <= 1'b0;
         href_dly_q  <= 1'b0;
      end else begin
         vsync_q     <= vsync_in;
         href_q      <= href_in;
         data_q      <= data_in;
         vsync_dly_q <= vsync_q;
         href_dly_q  <= href_q;
      end
   assign r_vsync    = vsync_q;
   assign r_href     = href_q;
   assign r_data     = data_q;
   assign vsync_rise = vsync_q & ~vsync_dly_q;
   assign vsync_fall = ~vsync_q & vsync_dly_q;
   assign href_rise  = href_q & ~href_dly_q;
   assign href_fall  = ~href_q & href_dly_q;
endmodule

// File: rtl/dvp_rgb565_capture.sv
// dvp_rgb565_capture: packs OV5640 DVP byte pairs into RGB565 pixels with frame/line markers
//   clk, reset     capture clock (cmos_pclk), synchronous active-high reset
//   enable         capture enable, sampled at vsync falling while armed
//   cmos_vsync, cmos_href, cmos_data   DVP pins, high byte first
//   pix_valid, pix_data, pix_sof, pix_eol   pixel strobe, RGB565 word, first-of-frame, last-of-line
//   frame_done     pulse at end of each captured frame; frame_cnt counts them (wraps)
//   err_line, err_frame   sticky malformed line / frame flags
//   DVP_CAPTURE_PATTERN_EN: pix_data becomes {hcnt[4:0], vcnt[5:0], hcnt[4:0]}
module dvp_rgb565_capture
   import dvp_rgb565_capture_pkg::*;
#(
   parameter int IMG_H       = 1920,
   parameter int IMG_V       = 1080,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        frame_done,
   output logic        err_line,
   output logic        err_frame,
   output logic [7:0]  frame_cnt
);
   localparam logic [HCNT_W-1:0] H_N       = HCNT_W'(IMG_H);
   localparam logic [HCNT_W-1:0] H_LAST    = HCNT_W'(IMG_H - 1);
   localparam logic [VCNT_W-1:0] V_N       = VCNT_W'(IMG_V);
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES > 0 ? SKIP_FRAMES - 1 : 0);

   logic       r_vsync, r_href, vs_rise, vs_fall, hr_rise, hr_fall;
   logic [7:0] r_data;

   dvp_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .vsync_in  (cmos_vsync),
      .href_in   (cmos_href),
      .data_in   (cmos_data),
      .r_vsync   (r_vsync),
      .r_href    (r_href),
      .r_data    (r_data),
      .vsync_rise(vs_rise),
      .vsync_fall(vs_fall),
      .href_rise (hr_rise),
      .href_fall (hr_fall)
   );

   cap_state_t        state_q, state_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [VCNT_W-1:0] vcnt_q, vcnt_d;
   logic              tog_q, tog_d;
   logic [7:0]        hi_q, hi_d;
   logic              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
   rgb565_t           pix_data_q, pix_data_d;
   logic              frame_done_q, frame_done_d, err_line_q, err_line_d, err_frame_q, err_frame_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;

   always_comb begin
      state_d      = state_q;
      skip_d       = skip_q;
      hcnt_d       = hcnt_q;
      vcnt_d       = vcnt_q;
      tog_d        = tog_q;
      hi_d         = hi_q;
      pix_valid_d  = 1'b0;
      pix_data_d   = pix_data_q;
      pix_sof_d    = 1'b0;
      pix_eol_d    = 1'b0;
      frame_done_d = 1'b0;
      err_line_d   = err_line_q;
      err_frame_d  = err_frame_q;
      frame_cnt_d  = frame_cnt_q;
      case (state_q)
         WAIT_VS: if (vs_rise) begin
            state_d = SKIP_FRAMES > 0 ? SKIP : ARM;
            skip_d  = '0;
         end
         SKIP: if (vs_rise) begin
            skip_d  = &skip_q ? skip_q : skip_q + 1'b1;
            state_d = skip_q == SKIP_LAST ? ARM : SKIP;
         end
         ARM: if (vs_fall && enable) begin
            state_d = ACTIVE;
            hcnt_d  = '0;
            vcnt_d  = '0;
            tog_d   = 1'b0;
         end
         ACTIVE: if (vs_rise) begin
            // a line still open when vsync rises is truncated and never counted
            state_d      = ARM;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            err_frame_d  = err_frame_q | (vcnt_q != V_N);
            err_line_d   = err_line_q | r_href;
         end else begin
            if (hr_rise) hcnt_d = '0;
            if (r_href && (hr_rise || !tog_q)) begin
               hi_d  = r_data;
               tog_d = 1'b1;
            end else if (r_href) begin
               tog_d  = 1'b0;
               hcnt_d = &hcnt_q ? hcnt_q : hcnt_q + 1'b1;
               if (hcnt_q < H_N && vcnt_q < V_N) begin
                  pix_valid_d = 1'b1;
`ifdef DVP_CAPTURE_PATTERN_EN
                  pix_data_d  = {hcnt_q[4:0], vcnt_q[5:0], hcnt_q[4:0]};
`else
                  pix_data_d  = {hi_q, r_data};
`endif
                  pix_sof_d   = hcnt_q == '0 && vcnt_q == '0;
                  pix_eol_d   = hcnt_q == H_LAST;
               end
            end
            // byte count is 2*hcnt plus a pending odd byte
            if (hr_fall) begin
               vcnt_d     = &vcnt_q ? vcnt_q : vcnt_q + 1'b1;
               err_line_d = err_line_q | tog_q | (hcnt_q != H_N);
               tog_d      = 1'b0;
            end
         end
         default: state_d = WAIT_VS;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         state_q      <= WAIT_VS;
         skip_q       <= '0;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         tog_q        <= 1'b0;
         hi_q         <= '0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= '0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         frame_done_q <= 1'b0;
         err_line_q   <= 1'b0;
         err_frame_q  <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         skip_q       <= skip_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         tog_q        <= tog_d;
         hi_q         <= hi_d;
         pix_valid_q  <= pix_valid_d;
         pix_data_q   <= pix_data_d;
         pix_sof_q    <= pix_sof_d;
         pix_eol_q    <= pix_eol_d;
         frame_done_q <= frame_done_d;
         err_line_q   <= err_line_d;
         err_frame_q  <= err_frame_d;
         frame_cnt_q  <= frame_cnt_d;
      end

   assign pix_valid  = pix_valid_q;
   assign pix_data   = pix_data_q;
   assign pix_sof    = pix_sof_q;
   assign pix_eol    = pix_eol_q;
   assign frame_done = frame_done_q;
   assign err_line   = err_line_q;
   assign err_frame  = err_frame_q;
   assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// tb_dvp_rgb565_capture: randomized DVP frames checked against a frame-level reference model
module tb_dvp_rgb565_capture;
   localparam int IMG_H = 4;
   localparam int IMG_V = 2;
   localparam int SKIP_FRAMES = 1;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, cmos_vsync = 1'b0, cmos_href = 1'b0;
   logic [7:0]  cmos_data = '0;
   logic        pix_valid, pix_sof, pix_eol, frame_done, err_line, err_frame;
   logic [15:0] pix_data;
   logic [7:0]  frame_cnt;

   dvp_rgb565_capture #(.IMG_H(IMG_H), .IMG_V(IMG_V), .SKIP_FRAMES(SKIP_FRAMES)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } pix_t;

   pix_t       exp_q[$];
   int         errors = 0, checks = 0;
   int         done_seen = 0, exp_done = 0, pulse_idx = 0, lines = 0;
   logic [7:0] exp_cnt = '0, seq_b = 8'h01;
   bit         cap = 1'b0, exp_el = 1'b0, exp_ef = 1'b0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic pix_t mk(int p, logic [7:0] hi, logic [7:0] lo);
      pix_t        e;
      logic [31:0] pv, lv;
      pv = p;
      lv = lines;
`ifdef DVP_CAPTURE_PATTERN_EN
      e.d = {pv[4:0], lv[5:0], pv[4:0]};
`else
      e.d = {hi, lo};
`endif
      e.sof = (p == 0 && lines == 0);
      e.eol = (p == IMG_H - 1);
      return e;
   endfunction

   always @(negedge clk)
      if (!reset) begin
         if (frame_done) done_seen++;
         if (pix_valid) begin
            if (exp_q.size() == 0) check("pix_extra", pix_valid, 0);
            else begin
               pix_t e;
               e = exp_q.pop_front();
               check("pix_data", pix_data, e.d);
               check("pix_sof", pix_sof, e.sof);
               check("pix_eol", pix_eol, e.eol);
            end
         end
      end

   task automatic check_zero(string tag);
      check({tag, "_valid"}, pix_valid, 0);
      check({tag, "_data"}, pix_data, 0);
      check({tag, "_sof"}, pix_sof, 0);
      check({tag, "_eol"}, pix_eol, 0);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_err_line"}, err_line, 0);
      check({tag, "_err_frame"}, err_frame, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
   endtask

   // hold=1 leaves href high so a following vsync or reset truncates the line
   task automatic send_line(int nb, bit seq, bit hold);
      logic [7:0] b, hi;
      hi = '0;
      cmos_href = 1'b1;
      for (int i = 0; i < nb; i++) begin
         b = seq ? seq_b : 8'($urandom);
         seq_b = seq_b + 8'd1;
         cmos_data = b;
         if (i % 2 == 0) hi = b;
         else if (cap && i / 2 < IMG_H && lines < IMG_V) exp_q.push_back(mk(i / 2, hi, b));
         tick(1);
         if (cap && lines < IMG_V && i == 1) check("latency_early", pix_valid, 0);
         if (cap && lines < IMG_V && i == 2) check("latency", pix_valid, 1);
      end
      if (!hold) begin
         cmos_href = 1'b0;
         if (cap) begin
            if (nb != 2 * IMG_H) exp_el = 1'b1;
            lines++;
         end
         tick(4);
         check("err_line", err_line, exp_el);
      end
   endtask

   task automatic vs_pulse(bit en);
      cmos_vsync = 1'b1;
      if (cap) begin
         if (cmos_href) exp_el = 1'b1;
         exp_done++;
         exp_cnt = exp_cnt + 8'd1;
         if (lines != IMG_V) exp_ef = 1'b1;
      end
      tick(1);
      cmos_href = 1'b0;
      tick(3);
      check("frame_done", done_seen, exp_done);
      check("frame_cnt", frame_cnt, exp_cnt);
      check("err_frame", err_frame, exp_ef);
      check("err_line_vs", err_line, exp_el);
      check("pix_missing", exp_q.size(), 0);
      enable = en;
      cap = pulse_idx >= SKIP_FRAMES && en;
      pulse_idx++;
      cmos_vsync = 1'b0;
      tick(3);
      lines = 0;
   endtask

   initial begin
      tick(3);
      check_zero("rst");
      reset = 1'b0;
      tick(2);
      vs_pulse(1);
      seq_b = 8'h01;
      send_line(8, 1, 0);
      send_line(8, 1, 0);
      vs_pulse(1);
      seq_b = 8'h01;
      send_line(8, 1, 0);
      send_line(8, 1, 0);
      vs_pulse(1);
      send_line(7, 0, 0);
      send_line(8, 0, 0);
      vs_pulse(1);
      for (int l = 0; l < 3; l++) send_line(8, 0, 0);
      vs_pulse(0);
      send_line(8, 0, 0);
      send_line(8, 0, 0);
      vs_pulse(1);
      enable = 1'b0;
      send_line(8, 0, 0);
      send_line(8, 0, 0);
      vs_pulse(1);
      send_line(8, 0, 0);
      send_line(3, 0, 1);
      vs_pulse(1);
      send_line(5, 0, 1);
      reset = 1'b1;
      cmos_href = 1'b0;
      tick(1);
      check_zero("midrst");
      reset = 1'b0;
      exp_q.delete();
      pulse_idx = 0;
      cap = 1'b0;
      lines = 0;
      exp_done = 0;
      done_seen = 0;
      exp_cnt = '0;
      exp_el = 1'b0;
      exp_ef = 1'b0;
      tick(2);
      vs_pulse(1);
      send_line(8, 0, 0);
      send_line(8, 0, 0);
      vs_pulse(1);
      send_line(8, 0, 0);
      send_line(8, 0, 0);
      vs_pulse(1);
      for (int f = 0; f < 6; f++) begin
         int nl;
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++) send_line($urandom_range(6, 10), 0, 0);
         vs_pulse($urandom_range(0, 3) != 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
